// File: rtl/screen_gen.sv
// screen_gen: Z88 blink LCD renderer. Walks the screen base file, fetches each
// cell's attribute pair and glyph row over a req/ack read port, applies the
// underline/reverse/grey/flash effects and packs the pixels into OUT_W-bit
// VRAM words, flushing a zero-padded partial word at the end of every line.
module screen_gen #(
  parameter int unsigned COLS    = 108,
  parameter int unsigned ROWS    = 64,
  parameter int unsigned OUT_W   = 4,
  parameter int unsigned WORD_AW = 8
) (
  input  logic                   clk,
  input  logic                   rin,
  input  logic                   clk_ena,
  input  logic                   lcdon,
  input  logic                   t_1s,
  input  logic                   t_5ms,
  input  logic [12:0]            pb0,
  input  logic [9:0]             pb1,
  input  logic [8:0]             pb2,
  input  logic [10:0]            pb3,
  input  logic [10:0]            sbr,
  output logic                   mem_req,
  output logic [21:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [7:0]             mem_data,
  output logic [6+WORD_AW-1:0]   vram_a,
  output logic [OUT_W-1:0]       vram_do,
  output logic                   vram_we,
  output logic                   frame
);

  // Packer is one bit wider than the worst case (OUT_W-1 leftover + 8 new)
  // so the glyph alignment below never needs a zero-width pad.
  localparam int unsigned PW = OUT_W + 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SBA_LO = 3'd1;
  localparam logic [2:0] SBA_HI = 3'd2;
  localparam logic [2:0] GLYPH  = 3'd3;
  localparam logic [2:0] EMIT   = 3'd4;
  localparam logic [2:0] EOL    = 3'd5;

  localparam logic [6:0]         LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]         LAST_LINE = 6'(ROWS - 1);
  localparam logic [4:0]         OUT_W_C   = 5'(OUT_W);
  localparam logic [WORD_AW-1:0] WORD_ONE  = WORD_AW'(1);
  localparam logic [WORD_AW-1:0] WORD_MAX  = {WORD_AW{1'b1}};

  // Registered state
  logic [2:0]          state_q, state_d;
  logic [6:0]          col_q, col_d;
  logic [5:0]          line_q, line_d;
  logic [WORD_AW-1:0]  word_q, word_d;
  logic                wsat_q, wsat_d;
  logic [8:0]          sba_q, sba_d;
  logic                hrs_q, hrs_d;
  logic                rev_q, rev_d;
  logic                fls_q, fls_d;
  logic                gry_q, gry_d;
  logic                und_q, und_d;
  logic [PW-1:0]       pk_q, pk_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                wrap_q, wrap_d;

  // Next values of the registered outputs
  logic                mem_req_d;
  logic [21:0]         mem_addr_d;
  logic [6+WORD_AW-1:0] vram_a_d;
  logic [OUT_W-1:0]    vram_do_d;
  logic                vram_we_d;
  logic                frame_d;

  // Combinational helpers
  logic [2:0]    grow;
  logic [21:0]   glyph_addr;
  logic [7:0]    gfx;
  logic          six;
  logic [7:0]    gbits;
  logic [PW-1:0] gext;
  logic [4:0]    nbits;
  logic          null_cell;
  logic          do_adv;
  logic          do_wr;
  logic          eol_clr;
  logic [6:0]    col_n;
  logic [5:0]    line_n;

  assign grow      = line_q[2:0];
  assign null_cell = hrs_q & rev_q & ~fls_q & gry_q;
  // Cursor cells and all lores cells are 6 pixels wide
  assign six       = ~hrs_q | (hrs_q & rev_q & fls_q);
  assign nbits     = six ? 5'd6 : 5'd8;

  // Glyph row address selected by font bank
  always_comb begin
    if (!hrs_q && sba_q[8:6] == 3'd7) begin
      glyph_addr = {pb0, sba_q[5:0], grow};
    end else if (!hrs_q) begin
      glyph_addr = {pb1, sba_q, grow};
    end else if (und_q && sba_q[8]) begin
      glyph_addr = {pb3, sba_q[7:0], grow};
    end else begin
      glyph_addr = {pb2, und_q, sba_q, grow};
    end
  end

  // Effects on the incoming glyph byte, then MSB-align it behind the packer contents
  always_comb begin
    gfx = mem_data;
    if (und_q && !hrs_q && grow == 3'd7) gfx = 8'hFF;
    if (rev_q) gfx = ~gfx;
    if (gry_q) gfx = gfx & {8{t_5ms}};
    if (fls_q) gfx = gfx & {8{t_1s}};
    gbits = six ? {gfx[5:0], 2'b00} : gfx;
    gext  = {gbits, {OUT_W{1'b0}}} >> cnt_q;
  end

  // Next-state logic for the FSM, fetch port, packer and VRAM writer
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    line_d     = line_q;
    word_d     = word_q;
    wsat_d     = wsat_q;
    sba_d      = sba_q;
    hrs_d      = hrs_q;
    rev_d      = rev_q;
    fls_d      = fls_q;
    gry_d      = gry_q;
    und_d      = und_q;
    pk_d       = pk_q;
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    vram_a_d   = vram_a;
    vram_do_d  = vram_do;
    vram_we_d  = 1'b0;
    // frame follows the EOL of the last line by one enabled cycle
    frame_d    = wrap_q;
    do_adv     = 1'b0;
    do_wr      = 1'b0;
    eol_clr    = 1'b0;
    col_n      = col_q + 7'd1;
    line_n     = (line_q == LAST_LINE) ? 6'd0 : line_q + 6'd1;

    // In each read state mem_req is high on entry; once it has been dropped
    // after the ack, the following cycle moves on.
    case (state_q)
      IDLE: begin
        state_d    = SBA_LO;
        mem_req_d  = 1'b1;
        mem_addr_d = {sbr, line_q[5:3], col_q, 1'b0};
      end
      SBA_LO: begin
        if (mem_req) begin
          if (mem_ack) begin
            sba_d[7:0] = mem_data;
            mem_req_d  = 1'b0;
          end
        end else begin
          state_d    = SBA_HI;
          mem_req_d  = 1'b1;
          mem_addr_d = {sbr, line_q[5:3], col_q, 1'b1};
        end
      end
      SBA_HI: begin
        if (mem_req) begin
          if (mem_ack) begin
            hrs_d     = mem_data[5];
            rev_d     = mem_data[4];
            fls_d     = mem_data[3];
            gry_d     = mem_data[2];
            und_d     = mem_data[1];
            sba_d[8]  = mem_data[0];
            mem_req_d = 1'b0;
          end
        end else if (null_cell) begin
          do_adv = 1'b1;
        end else begin
          state_d    = GLYPH;
          mem_req_d  = 1'b1;
          mem_addr_d = glyph_addr;
        end
      end
      GLYPH: begin
        if (mem_req) begin
          if (mem_ack) begin
            pk_d      = pk_q | gext;
            cnt_d     = cnt_q + nbits;
            mem_req_d = 1'b0;
          end
        end else if (cnt_q >= OUT_W_C) begin
          state_d = EMIT;
        end else begin
          do_adv = 1'b1;
        end
      end
      EMIT: begin
        do_wr = 1'b1;
        pk_d  = pk_q << OUT_W;
        cnt_d = cnt_q - OUT_W_C;
        if (cnt_d < OUT_W_C) do_adv = 1'b1;
      end
      EOL: begin
        // Lower packer bits are always zero, so the top slice is already padded
        do_wr      = (cnt_q != 5'd0);
        eol_clr    = 1'b1;
        pk_d       = '0;
        cnt_d      = 5'd0;
        col_d      = 7'd0;
        line_d     = line_n;
        wrap_d     = (line_q == LAST_LINE);
        state_d    = SBA_LO;
        mem_req_d  = 1'b1;
        mem_addr_d = {sbr, line_n[5:3], 7'd0, 1'b0};
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Column advance: next cell, or end of line after the last column
    if (do_adv) begin
      if (col_q == LAST_COL) begin
        state_d = EOL;
      end else begin
        col_d      = col_n;
        state_d    = SBA_LO;
        mem_req_d  = 1'b1;
        mem_addr_d = {sbr, line_q[5:3], col_n, 1'b0};
      end
    end

    // VRAM write; the index saturates at its maximum and later writes are dropped
    if (do_wr && !wsat_q) begin
      vram_we_d = 1'b1;
      vram_a_d  = {line_q, word_q};
      vram_do_d = pk_q[PW-1 -: OUT_W];
      if (word_q == WORD_MAX) wsat_d = 1'b1;
      else                    word_d = word_q + WORD_ONE;
    end

    if (eol_clr) begin
      word_d = '0;
      wsat_d = 1'b0;
    end

    // Display off: synchronous return to idle
    if (!lcdon) begin
      state_d   = IDLE;
      col_d     = 7'd0;
      line_d    = 6'd0;
      word_d    = '0;
      wsat_d    = 1'b0;
      pk_d      = '0;
      cnt_d     = 5'd0;
      wrap_d    = 1'b0;
      mem_req_d = 1'b0;
      vram_a_d  = '0;
      vram_we_d = 1'b0;
      frame_d   = 1'b0;
    end
  end

  // State and output registers, advanced only on enabled cycles
  always_ff @(posedge clk or posedge rin) begin
    if (rin) begin
      state_q  <= IDLE;
      col_q    <= 7'd0;
      line_q   <= 6'd0;
      word_q   <= '0;
      wsat_q   <= 1'b0;
      sba_q    <= 9'd0;
      hrs_q    <= 1'b0;
      rev_q    <= 1'b0;
      fls_q    <= 1'b0;
      gry_q    <= 1'b0;
      und_q    <= 1'b0;
      pk_q     <= '0;
      cnt_q    <= 5'd0;
      wrap_q   <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= 22'd0;
      vram_a   <= '0;
      vram_do  <= '0;
      vram_we  <= 1'b0;
      frame    <= 1'b0;
    end else if (clk_ena) begin
      state_q  <= state_d;
      col_q    <= col_d;
      line_q   <= line_d;
      word_q   <= word_d;
      wsat_q   <= wsat_d;
      sba_q    <= sba_d;
      hrs_q    <= hrs_d;
      rev_q    <= rev_d;
      fls_q    <= fls_d;
      gry_q    <= gry_d;
      und_q    <= und_d;
      pk_q     <= pk_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      vram_a   <= vram_a_d;
      vram_do  <= vram_do_d;
      vram_we  <= vram_we_d;
      frame    <= frame_d;
    end
  end

endmodule
